// File: rtl/sc_point_mover_if.sv
// Player-point bus: debounced button levels and obstacle row in, player row and game status out.
interface sc_point_mover_if #(
  parameter int DATAWIDTH_BUS = 8
);
  localparam int POSW = $clog2(DATAWIDTH_BUS);

  logic                     sc_point_mover_start_In;
  logic                     sc_point_mover_left_In;
  logic                     sc_point_mover_right_In;
  logic [DATAWIDTH_BUS-1:0] sc_point_mover_obsRow_In;
  logic [DATAWIDTH_BUS-1:0] sc_point_mover_row_Out;
  logic [POSW-1:0]          sc_point_mover_pos_Out;
  logic [7:0]               sc_point_mover_moves_Out;
  logic [1:0]               sc_point_mover_state_Out;
  logic                     sc_point_mover_hit_Out;

  modport master (
    output sc_point_mover_start_In, sc_point_mover_left_In, sc_point_mover_right_In,
           sc_point_mover_obsRow_In,
    input  sc_point_mover_row_Out, sc_point_mover_pos_Out, sc_point_mover_moves_Out,
           sc_point_mover_state_Out, sc_point_mover_hit_Out
  );

  modport slave (
    input  sc_point_mover_start_In, sc_point_mover_left_In, sc_point_mover_right_In,
           sc_point_mover_obsRow_In,
    output sc_point_mover_row_Out, sc_point_mover_pos_Out, sc_point_mover_moves_Out,
           sc_point_mover_state_Out, sc_point_mover_hit_Out
  );
endinterface

// File: rtl/sc_point_mover.sv
// Player-point register and IDLE/PLAY/HIT game FSM for the 8x8 LED-matrix game.
// Moves the one-hot point on button rising edges and flags collision with the obstacle row.
module sc_point_mover #(
  parameter int                     DATAWIDTH_BUS = 8,
  parameter logic [DATAWIDTH_BUS-1:0] INIT_ROW    = 8'b00010000
) (
  input  logic              sc_point_mover_CLOCK_50,
  input  logic              sc_point_mover_RESET_InHigh,
  sc_point_mover_if.slave   bus
);
  localparam int POSW = $clog2(DATAWIDTH_BUS);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    PLAY   = 2'b01,
    HIT    = 2'b10,
    UNUSED = 2'b11
  } state_t;

  state_t                   stateR, stateNext_s;
  logic [DATAWIDTH_BUS-1:0] rowR, rowNext_s;
  logic [POSW-1:0]          posR, posNext_s;
  logic [7:0]               movesR, movesNext_s;
  logic                     hitR, hitNext_s;
  logic                     prevStartR, prevLeftR, prevRightR;
  logic                     riseStart_s, riseLeft_s, riseRight_s;

  function automatic logic [POSW-1:0] encodeRow(input logic [DATAWIDTH_BUS-1:0] row);
    logic [POSW-1:0] enc;
    enc = {POSW{1'b0}};
    for (int i = 0; i < DATAWIDTH_BUS; i++) begin
      if (row[i]) begin
        enc = POSW'(i);
      end else begin
        enc = enc;
      end
    end
    return enc;
  endfunction

  assign riseStart_s = bus.sc_point_mover_start_In & ~prevStartR;
  assign riseLeft_s  = bus.sc_point_mover_left_In  & ~prevLeftR;
  assign riseRight_s = bus.sc_point_mover_right_In & ~prevRightR;

  // Next-state, point movement and collision decode
  always_comb begin
    stateNext_s = stateR;
    rowNext_s   = rowR;
    movesNext_s = movesR;
    hitNext_s   = hitR;
    case (stateR)
      IDLE: begin
        rowNext_s = INIT_ROW;
        hitNext_s = 1'b0;
        if (riseStart_s) begin
          stateNext_s = PLAY;
          movesNext_s = 8'd0;
        end else begin
          stateNext_s = IDLE;
        end
      end
      PLAY: begin
        if (riseLeft_s && !riseRight_s && !rowR[DATAWIDTH_BUS-1]) begin
          rowNext_s   = rowR << 1;
          movesNext_s = movesR + 8'd1;
        end else if (riseRight_s && !riseLeft_s && !rowR[0]) begin
          rowNext_s   = rowR >> 1;
          movesNext_s = movesR + 8'd1;
        end else begin
          rowNext_s   = rowR;
        end
        // Collision is judged against the point as it stands, not where it is moving to.
        if ((rowR & bus.sc_point_mover_obsRow_In) != {DATAWIDTH_BUS{1'b0}}) begin
          stateNext_s = HIT;
          hitNext_s   = 1'b1;
        end else begin
          stateNext_s = PLAY;
        end
      end
      HIT: begin
        if (riseStart_s) begin
          stateNext_s = IDLE;
          rowNext_s   = INIT_ROW;
          movesNext_s = 8'd0;
          hitNext_s   = 1'b0;
        end else begin
          stateNext_s = HIT;
        end
      end
      default: begin
        stateNext_s = IDLE;
        rowNext_s   = INIT_ROW;
        movesNext_s = 8'd0;
        hitNext_s   = 1'b0;
      end
    endcase
    posNext_s = encodeRow(rowNext_s);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge sc_point_mover_CLOCK_50) begin
    if (sc_point_mover_RESET_InHigh) begin
      stateR     <= IDLE;
      rowR       <= INIT_ROW;
      posR       <= encodeRow(INIT_ROW);
      movesR     <= 8'd0;
      hitR       <= 1'b0;
      // Held-through-reset buttons must not look like a fresh press.
      prevStartR <= 1'b1;
      prevLeftR  <= 1'b1;
      prevRightR <= 1'b1;
    end else begin
      stateR     <= stateNext_s;
      rowR       <= rowNext_s;
      posR       <= posNext_s;
      movesR     <= movesNext_s;
      hitR       <= hitNext_s;
      prevStartR <= bus.sc_point_mover_start_In;
      prevLeftR  <= bus.sc_point_mover_left_In;
      prevRightR <= bus.sc_point_mover_right_In;
    end
  end

  assign bus.sc_point_mover_row_Out   = rowR;
  assign bus.sc_point_mover_pos_Out   = posR;
  assign bus.sc_point_mover_moves_Out = movesR;
  assign bus.sc_point_mover_state_Out = stateR;
  assign bus.sc_point_mover_hit_Out   = hitR;
endmodule

// File: tb/tb_sc_point_mover.sv
// Directed vector bench for sc_point_mover: one table row per clock, plus a move-counter wrap sequence.
module tb_sc_point_mover;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   testsRun = 0;
  int   testsFailed = 0;

  sc_point_mover_if #(.DATAWIDTH_BUS(8)) bus ();

  sc_point_mover #(.DATAWIDTH_BUS(8), .INIT_ROW(8'b00010000)) dut (
    .sc_point_mover_CLOCK_50    (clk),
    .sc_point_mover_RESET_InHigh(rst),
    .bus                        (bus)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic       left;
    logic       right;
    logic [7:0] obs;
    logic [7:0] row;
    logic [2:0] pos;
    logic [7:0] moves;
    logic [1:0] state;
    logic       hit;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic l, input logic rt,
                              input logic [7:0] o, input logic [7:0] row, input logic [2:0] pos,
                              input logic [7:0] mv, input logic [1:0] st, input logic h);
    vec_t v;
    v.rst = r; v.start = s; v.left = l; v.right = rt; v.obs = o;
    v.row = row; v.pos = pos; v.moves = mv; v.state = st; v.hit = h;
    return v;
  endfunction

  task automatic checkVal(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic checkAll(input int idx, input vec_t v);
    checkVal("row",   idx, bus.sc_point_mover_row_Out, v.row);
    checkVal("pos",   idx, {5'd0, bus.sc_point_mover_pos_Out}, {5'd0, v.pos});
    checkVal("moves", idx, bus.sc_point_mover_moves_Out, v.moves);
    checkVal("state", idx, {6'd0, bus.sc_point_mover_state_Out}, {6'd0, v.state});
    checkVal("hit",   idx, {7'd0, bus.sc_point_mover_hit_Out}, {7'd0, v.hit});
  endtask

  task automatic drive(input logic r, input logic s, input logic l, input logic rt, input logic [7:0] o);
    rst = r;
    bus.sc_point_mover_start_In  = s;
    bus.sc_point_mover_left_In   = l;
    bus.sc_point_mover_right_In  = rt;
    bus.sc_point_mover_obsRow_In = o;
  endtask

  initial begin
    //             rst  st   lf   rt   obs    row    pos   moves  state  hit
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b00,1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b00,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b00,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b01,1'b0)); // 3 start
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00, 8'h20,3'd5, 8'd1, 2'b01,1'b0)); // left rises
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00, 8'h20,3'd5, 8'd1, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00, 8'h20,3'd5, 8'd1, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00, 8'h20,3'd5, 8'd1, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h20,3'd5, 8'd1, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,8'h00, 8'h10,3'd4, 8'd2, 2'b01,1'b0)); // 9 right
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd2, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,8'h00, 8'h08,3'd3, 8'd3, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h08,3'd3, 8'd3, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,8'h00, 8'h04,3'd2, 8'd4, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h04,3'd2, 8'd4, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,8'h00, 8'h02,3'd1, 8'd5, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h02,3'd1, 8'd5, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,8'h00, 8'h01,3'd0, 8'd6, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h01,3'd0, 8'd6, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,8'h00, 8'h01,3'd0, 8'd6, 2'b01,1'b0)); // 19 saturate
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h01,3'd0, 8'd6, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b1,8'h00, 8'h01,3'd0, 8'd6, 2'b01,1'b0)); // 21 both
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h01,3'd0, 8'd6, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00, 8'h02,3'd1, 8'd7, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h02, 8'h02,3'd1, 8'd7, 2'b10,1'b1)); // 24 collide
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00, 8'h02,3'd1, 8'd7, 2'b10,1'b1)); // frozen
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'hff, 8'h02,3'd1, 8'd7, 2'b10,1'b1));
    vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b00,1'b0)); // 27 restart
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b00,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b00,1'b0)); // IDLE ignores left
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b00,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,8'h00, 8'h08,3'd3, 8'd1, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h08,3'd3, 8'd1, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,8'h00, 8'h04,3'd2, 8'd2, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h04,3'd2, 8'd2, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,8'h00, 8'h02,3'd1, 8'd3, 2'b01,1'b0));
    vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b00,1'b0)); // 37 mid-game reset
    vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b00,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b00,1'b0)); // start held
    vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b00,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b00,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b1,1'b0,8'h10, 8'h20,3'd5, 8'd1, 2'b10,1'b1)); // 43 move+hit
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h20,3'd5, 8'd1, 2'b10,1'b1));
    vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b00,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b00,1'b0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b01,1'b0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,8'h08, 8'h08,3'd3, 8'd1, 2'b01,1'b0)); // 48 obs on target only
    vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h08,3'd3, 8'd1, 2'b01,1'b0));

    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].left, vecs[i].right, vecs[i].obs);
      @(posedge clk);
      #1;
      checkAll(i, vecs[i]);
      @(negedge clk);
    end

    // Counter wrap: from row 08 / moves 1, 255 alternating moves bring moves back to 0.
    for (int k = 0; k < 255; k++) begin
      drive(1'b0, 1'b0, (k % 2) == 0, (k % 2) == 1, 8'h00);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
    end
    checkAll(100, mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h10,3'd4, 8'd0, 2'b01,1'b0));
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    @(negedge clk);
    checkAll(101, mk(1'b0,1'b0,1'b0,1'b0,8'h00, 8'h20,3'd5, 8'd1, 2'b01,1'b0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
